// File: rtl/bus_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sram_pkg
//  Description : Shared types and constants for the bus_sram_responder block:
//                FSM state encoding, beat counter width, bus field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_sram_pkg;

  // Bus field widths
  localparam int DATA_W     = 32;
  localparam int BE_W       = 4;
  localparam int BURST_W    = 8;

  // Beat counter must hold 1..256 beats
  localparam int BEAT_CNT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_READ     = 3'd2,
    ST_READ_END = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

endpackage : bus_sram_pkg
`default_nettype wire

// File: rtl/bus_sram_mem.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sram_mem
//  Description : Single-port 2^ADDR_WIDTH x 32 RAM with per-byte write enable
//                and a one-cycle registered read. The read register only
//                loads when re_i is high, so it holds its word while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_sram_mem
  import bus_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [BE_W-1:0]       we_i,
  input  logic                  re_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane writes and gated registered read; contents are never cleared
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BE_W; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : bus_sram_mem
`default_nettype wire

// File: rtl/bus_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sram_responder
//  Description : Gecko5 burst-bus target serving single and burst reads and
//                writes from an internal byte-writable SRAM. All bus outputs
//                are zero when not addressed so they can be OR-combined.
//  Options     : BUS_SRAM_RESPONDER_BOUNDS_EN - when defined, bursts crossing
//                the window top are rejected with an errorOUT pulse; when
//                undefined, the word index wraps modulo the depth.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_sram_responder
  import bus_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          ADDR_WIDTH   = 10
) (
  input  logic               system_clock,
  input  logic               system_reset,
  input  logic [DATA_W-1:0]  address_dataIN,
  input  logic [BE_W-1:0]    byte_enableIN,
  input  logic [BURST_W-1:0] busrt_sizeIN,
  input  logic               read_n_writeIN,
  input  logic               begin_transactionIN,
  input  logic               end_transactionIN,
  input  logic               data_validIN,
  input  logic               busyIN,
  output logic [DATA_W-1:0]  address_dataOUT,
  output logic               end_transactionOUT,
  output logic               data_validOUT,
  output logic               busyOUT,
  output logic               errorOUT
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q,   idx_d;
  logic [BEAT_CNT_W-1:0] cnt_q,   cnt_d;
  logic [BE_W-1:0]       be_q,    be_d;
  logic                  valid_q, valid_d;

  logic [BE_W-1:0]       w_mem_we;
  logic                  w_mem_re;
  logic [DATA_W-1:0]     w_mem_rdata;
  logic                  w_hit;
  logic [ADDR_WIDTH-1:0] w_req_idx;
  logic                  w_bounds_err;
  logic                  w_consume;
  logic                  w_unused_addr_lsb;

  // Byte offset bits of the begin address carry no meaning for word access
  assign w_unused_addr_lsb = ^address_dataIN[1:0];

  assign w_hit     = begin_transactionIN &&
                     (address_dataIN[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);
  assign w_req_idx = address_dataIN[ADDR_WIDTH+1:2];
  assign w_consume = valid_q & ~busyIN;

`ifdef BUS_SRAM_RESPONDER_BOUNDS_EN
  localparam logic [31:0] c_LAST_IDX = {{(32-ADDR_WIDTH){1'b0}}, {ADDR_WIDTH{1'b1}}};
  logic [31:0] w_req_last;
  assign w_req_last   = 32'(w_req_idx) + 32'(busrt_sizeIN);
  assign w_bounds_err = (w_req_last > c_LAST_IDX);
`else
  assign w_bounds_err = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      be_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic; cnt_q counts beats still to write or still to fetch
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    be_d     = be_q;
    valid_d  = valid_q;
    w_mem_we = '0;
    w_mem_re = 1'b0;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (w_hit) begin
          idx_d = w_req_idx;
          cnt_d = BEAT_CNT_W'(busrt_sizeIN) + BEAT_CNT_W'(1);
          be_d  = byte_enableIN;
`ifdef BUS_SRAM_RESPONDER_BOUNDS_EN
          if (w_bounds_err) begin
            state_d = ST_ERROR;
          end else
`endif
          if (read_n_writeIN) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (data_validIN && (cnt_q != '0)) begin
          w_mem_we = be_q;
          idx_d    = idx_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end
        if (end_transactionIN) begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (end_transactionIN) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if ((!valid_q || w_consume) && (cnt_q != '0)) begin
          // Output register empty or being drained: fetch the next beat
          w_mem_re = 1'b1;
          idx_d    = idx_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
          valid_d  = 1'b1;
        end else if (w_consume) begin
          // Last beat taken by the initiator
          valid_d = 1'b0;
          state_d = ST_READ_END;
        end
      end
      ST_READ_END: begin
        state_d = ST_IDLE;
      end
`ifdef BUS_SRAM_RESPONDER_BOUNDS_EN
      ST_ERROR: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  bus_sram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (system_clock),
    .addr_i  (idx_q),
    .we_i    (w_mem_we),
    .re_i    (w_mem_re),
    .wdata_i (address_dataIN),
    .rdata_o (w_mem_rdata)
  );

  assign address_dataOUT    = valid_q ? w_mem_rdata : '0;
  assign data_validOUT      = valid_q;
  assign busyOUT            = 1'b0;
  assign end_transactionOUT = (state_q == ST_READ_END) || (state_q == ST_ERROR);
`ifdef BUS_SRAM_RESPONDER_BOUNDS_EN
  assign errorOUT           = (state_q == ST_ERROR);
`else
  assign errorOUT           = 1'b0;
`endif

endmodule : bus_sram_responder
`default_nettype wire

// File: tb/tb_bus_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_sram_responder
//  Description : Self-checking bench for bus_sram_responder: directed cases
//                plus randomized bursts against an array model of the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_sram_responder;

  localparam logic [31:0] BASE  = 32'h8000_1000;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;

  logic        clk;
  logic        system_reset;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  busrt_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        end_transactionOUT;
  logic        data_validOUT;
  logic        busyOUT;
  logic        errorOUT;

  logic [31:0] model [DEPTH];
  logic [31:0] wdata [256];
  int          n_checks;
  int          n_fail;

  bus_sram_responder #(
    .BASE_ADDRESS (BASE),
    .ADDR_WIDTH   (AW)
  ) dut (
    .system_clock        (clk),
    .system_reset        (system_reset),
    .address_dataIN      (address_dataIN),
    .byte_enableIN       (byte_enableIN),
    .busrt_sizeIN        (busrt_sizeIN),
    .read_n_writeIN      (read_n_writeIN),
    .begin_transactionIN (begin_transactionIN),
    .end_transactionIN   (end_transactionIN),
    .data_validIN        (data_validIN),
    .busyIN              (busyIN),
    .address_dataOUT     (address_dataOUT),
    .end_transactionOUT  (end_transactionOUT),
    .data_validOUT       (data_validOUT),
    .busyOUT             (busyOUT),
    .errorOUT            (errorOUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_dv"},  32'(data_validOUT),      0);
    check_eq({tag, "_d"},   address_dataOUT,         0);
    check_eq({tag, "_end"}, 32'(end_transactionOUT), 0);
    check_eq({tag, "_err"}, 32'(errorOUT),           0);
  endtask

  function automatic bit bounds_err(input int idx, input int n);
`ifdef BUS_SRAM_RESPONDER_BOUNDS_EN
    return (idx + n - 1) > (DEPTH - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Burst write of wdata[0..n-1]; ends with the last beat or after one extra ignored beat
  task automatic wr(input logic [31:0] addr, input logic [3:0] be, input int n, input bit end_on_last);
    int idx;
    bit err;
    idx = int'(addr[AW+1:2]);
    err = bounds_err(idx, n);
    address_dataIN      = addr;
    byte_enableIN       = be;
    busrt_sizeIN        = 8'(n - 1);
    read_n_writeIN      = 1'b0;
    begin_transactionIN = 1'b1;
    step();
    begin_transactionIN = 1'b0;
    byte_enableIN       = $urandom;
    check_eq("wr_err", 32'(errorOUT), 32'(err));
    check_eq("wr_end", 32'(end_transactionOUT), 32'(err));
    check_eq("wr_dv",  32'(data_validOUT), 0);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        data_validIN   = 1'b0;
        address_dataIN = $urandom;
        step();
      end
      data_validIN      = 1'b1;
      address_dataIN    = wdata[i];
      end_transactionIN = end_on_last && (i == n - 1);
      step();
      if (!err) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model[(idx + i) % DEPTH][b*8 +: 8] = wdata[i][b*8 +: 8];
        end
      end
    end
    if (!end_on_last) begin
      data_validIN   = 1'b1;
      address_dataIN = $urandom;
      step();
      data_validIN      = 1'b0;
      end_transactionIN = 1'b1;
      step();
    end
    data_validIN      = 1'b0;
    end_transactionIN = 1'b0;
  endtask

  // Burst read; bmode 0 random stalls, 1 none, 2 stall beat 1 for 3 cycles; abort_at>=0 aborts
  task automatic rd(input logic [31:0] addr, input int n, input int bmode, input int abort_at);
    int idx, beat, cyc, last_c, brun;
    bit err, done, first;
    idx = int'(addr[AW+1:2]);
    err = bounds_err(idx, n);
    address_dataIN      = addr;
    byte_enableIN       = $urandom;
    busrt_sizeIN        = 8'(n - 1);
    read_n_writeIN      = 1'b1;
    begin_transactionIN = 1'b1;
    step();
    begin_transactionIN = 1'b0;
    address_dataIN      = $urandom;
    if (err) begin
      check_eq("rderr_err", 32'(errorOUT), 1);
      check_eq("rderr_end", 32'(end_transactionOUT), 1);
      step();
      check_quiet("rderr_after");
      return;
    end
    check_eq("rd_err", 32'(errorOUT), 0);
    beat = 0; cyc = 1; last_c = 0; brun = 0; done = 0; first = 1;
    while (!done && cyc < 2000) begin
      if (data_validOUT) begin
        check_eq("rd_data", address_dataOUT, model[(idx + beat) % DEPTH]);
        check_eq("rd_overrun", 32'(beat < n), 1);
        if (first) begin
          check_eq("rd_latency", 32'(cyc), 2);
          first = 0;
        end
      end else begin
        check_eq("rd_zero", address_dataOUT, 0);
      end
      if (end_transactionOUT) begin
        check_eq("rd_endcnt", 32'(beat), 32'(n));
        check_eq("rd_endlat", 32'(cyc), 32'(last_c + 1));
        done = 1;
      end else begin
        if (abort_at >= 0 && beat == abort_at) begin
          end_transactionIN = 1'b1;
          busyIN            = 1'b1;
          step();
          end_transactionIN = 1'b0;
          busyIN            = 1'b0;
          check_eq("ab_dv", 32'(data_validOUT), 0);
          check_eq("ab_d",  address_dataOUT, 0);
          step();
          check_quiet("ab_after");
          return;
        end
        case (bmode)
          0:       busyIN = ($urandom_range(0, 2) == 0);
          2:       busyIN = data_validOUT && (beat == 1) && (brun < 3);
          default: busyIN = 1'b0;
        endcase
        if (busyIN && data_validOUT && beat == 1) brun++;
        if (data_validOUT && !busyIN) begin
          beat++;
          last_c = cyc;
        end
        step();
        cyc++;
      end
    end
    busyIN = 1'b0;
    if (!done) begin
      check_eq("rd_timeout", 0, 1);
    end else begin
      step();
      check_quiet("rd_after");
    end
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    system_reset        = 1'b1;
    address_dataIN      = '0;
    byte_enableIN       = '0;
    busrt_sizeIN        = '0;
    read_n_writeIN      = 1'b0;
    begin_transactionIN = 1'b0;
    end_transactionIN   = 1'b0;
    data_validIN        = 1'b0;
    busyIN              = 1'b0;
    repeat (3) step();
    check_quiet("reset");
    check_eq("reset_busy", 32'(busyOUT), 0);
    system_reset = 1'b0;
    step();

    // Fill the whole RAM so every model word is known
    for (int blk = 0; blk < DEPTH / 256; blk++) begin
      for (int i = 0; i < 256; i++) wdata[i] = $urandom;
      wr(BASE + 32'(blk * 1024), 4'hF, 256, 1'b1);
    end

    // Single write / single read
    wdata[0] = 32'hDEADBEEF;
    wr(BASE + 32'h10, 4'hF, 1, 1'b1);
    rd(BASE + 32'h10, 1, 1, -1);

    // 4-beat write then stalled 4-beat read
    for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
    wr(BASE, 4'hF, 4, 1'b0);
    rd(BASE, 4, 2, -1);

    // Partial byte enables
    wdata[0] = 32'h11223344;
    wr(BASE + 32'h40, 4'hF, 1, 1'b1);
    wdata[0] = 32'hAABBCCDD;
    wr(BASE + 32'h40, 4'b0101, 1, 1'b0);
    rd(BASE + 32'h43, 1, 1, -1);

    // Burst crossing the window top
    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    wr(BASE + 32'(4 * (DEPTH - 2)), 4'hF, 4, 1'b1);
    rd(BASE + 32'(4 * (DEPTH - 2)), 2, 1, -1);
    rd(BASE, 2, 1, -1);
    rd(BASE + 32'(4 * (DEPTH - 2)), 4, 0, -1);

    // Begins outside the window are ignored
    address_dataIN      = BASE + 32'h1000;
    busrt_sizeIN        = 8'd3;
    read_n_writeIN      = 1'b1;
    begin_transactionIN = 1'b1;
    step();
    begin_transactionIN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_quiet("outwin_rd");
      step();
    end
    address_dataIN      = BASE - 32'h1000 + 32'h10;
    busrt_sizeIN        = 8'd1;
    read_n_writeIN      = 1'b0;
    byte_enableIN       = 4'hF;
    begin_transactionIN = 1'b1;
    step();
    begin_transactionIN = 1'b0;
    data_validIN        = 1'b1;
    address_dataIN      = 32'h0BAD_F00D;
    step();
    step();
    data_validIN      = 1'b0;
    end_transactionIN = 1'b1;
    step();
    end_transactionIN = 1'b0;
    check_quiet("outwin_wr");
    rd(BASE + 32'h10, 2, 1, -1);

    // Aborted read, then a normal one
    rd(BASE, 8, 1, 3);
    rd(BASE + 32'h80, 8, 0, -1);

    // Reset in the middle of a read
    address_dataIN      = BASE + 32'h20;
    busrt_sizeIN        = 8'd7;
    read_n_writeIN      = 1'b1;
    begin_transactionIN = 1'b1;
    step();
    begin_transactionIN = 1'b0;
    step();
    step();
    system_reset = 1'b1;
    step();
    check_quiet("midreset");
    system_reset = 1'b0;
    step();
    check_quiet("postreset");
    rd(BASE + 32'h20, 8, 0, -1);

    // Long read exercising the full counter range
    rd(BASE, 256, 0, -1);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      int          n;
      logic [31:0] addr;
      n    = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 64) : $urandom_range(1, 8);
      addr = BASE + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < n; i++) wdata[i] = $urandom;
        wr(addr, 4'($urandom), n, 1'($urandom_range(0, 1)));
      end else begin
        rd(addr, n, 0, ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bus_sram_responder
`default_nettype wire
